// File: rtl/mmu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmu_pkg
// Brief    : Shared types, exception codes and field offsets for the MMU/TLB
// Revision : 1.0
// ============================================================================
package mmu_pkg;

    typedef enum logic [2:0] {
        EXC_NONE    = 3'd0,
        EXC_ADE     = 3'd1,
        EXC_REFILL  = 3'd2,
        EXC_INVALID = 3'd3,
        EXC_MOD     = 3'd4
    } exc_e;

    localparam logic [2:0] KSEG0 = 3'b100;
    localparam logic [2:0] KSEG1 = 3'b101;

    localparam int LO_G       = 0;
    localparam int LO_V       = 1;
    localparam int LO_D       = 2;
    localparam int LO_C_LSB   = 3;
    localparam int LO_C_MSB   = 5;
    localparam int LO_PFN_LSB = 6;
    localparam int LO_PFN_MSB = 25;

    localparam logic [2:0] C_CACHEABLE = 3'd3;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        cached;
        exc_e        exc;
    } xlat_t;

    // Segment decode and exception priority shared by both translation ports.
    function automatic xlat_t xlat_resolve(
        input logic [31:0] va,
        input logic        ade,
        input logic        hit,
        input logic [19:0] pfn,
        input logic [2:0]  c,
        input logic        d,
        input logic        v,
        input logic        we,
        input logic        k0_cached
    );
        xlat_t r;
        r.paddr  = '0;
        r.cached = 1'b0;
        r.exc    = EXC_NONE;
        if (ade) begin
            r.exc = EXC_ADE;
        end else if (va[31:29] == KSEG0 || va[31:29] == KSEG1) begin
            r.paddr  = {3'b000, va[28:0]};
            r.cached = (va[31:29] == KSEG0) && k0_cached;
        end else if (!hit) begin
            r.exc = EXC_REFILL;
        end else if (!v) begin
            r.exc = EXC_INVALID;
        end else if (we && !d) begin
            r.exc = EXC_MOD;
        end else begin
            r.paddr  = {pfn, va[11:0]};
            r.cached = (c == C_CACHEABLE);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmu_tlb_if.sv
`default_nettype none
// ============================================================================
// Module   : mmu_tlb_if
// Brief    : I/D translation ports and CP0 TLB-instruction bus of the MMU
// Revision : 1.0
// ============================================================================
interface mmu_tlb_if #(
    parameter int TLB_ENTRIES = 16
);
    localparam int IDX_W = $clog2(TLB_ENTRIES);

    logic             i_req;
    logic             i_stall;
    logic [31:0]      i_vaddr;
    logic             i_valid;
    logic [31:0]      i_paddr;
    logic             i_cached;
    logic [2:0]       i_exc;

    logic             d_req;
    logic             d_we;
    logic [1:0]       d_width;
    logic             d_clr;
    logic             d_stall;
    logic [31:0]      d_vaddr;
    logic             d_valid;
    logic [31:0]      d_paddr;
    logic             d_cached;
    logic [2:0]       d_exc;

    logic             k0_cached;
    logic [31:0]      cp0_entryhi;
    logic [31:0]      cp0_entrylo0;
    logic [31:0]      cp0_entrylo1;
    logic [IDX_W-1:0] cp0_index;
    logic             tlbwi;
    logic             tlbwr;
    logic             tlbp;
    logic             tlbr;
    logic [IDX_W-1:0] random_o;
    logic             tlbp_done;
    logic             tlbp_miss;
    logic [IDX_W-1:0] tlbp_index;
    logic             tlbr_done;
    logic [31:0]      tlbr_entryhi;
    logic [31:0]      tlbr_entrylo0;
    logic [31:0]      tlbr_entrylo1;

    modport master (
        output i_req, i_stall, i_vaddr,
        input  i_valid, i_paddr, i_cached, i_exc,
        output d_req, d_we, d_width, d_clr, d_stall, d_vaddr,
        input  d_valid, d_paddr, d_cached, d_exc,
        output k0_cached, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index,
        output tlbwi, tlbwr, tlbp, tlbr,
        input  random_o, tlbp_done, tlbp_miss, tlbp_index,
        input  tlbr_done, tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1
    );

    modport slave (
        input  i_req, i_stall, i_vaddr,
        output i_valid, i_paddr, i_cached, i_exc,
        input  d_req, d_we, d_width, d_clr, d_stall, d_vaddr,
        output d_valid, d_paddr, d_cached, d_exc,
        input  k0_cached, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index,
        input  tlbwi, tlbwr, tlbp, tlbr,
        output random_o, tlbp_done, tlbp_miss, tlbp_index,
        output tlbr_done, tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1
    );

endinterface
`default_nettype wire

// File: rtl/mmu_tlb_lookup.sv
`default_nettype none
// ============================================================================
// Module   : mmu_tlb_lookup
// Brief    : Combinational CAM match over the TLB; lowest matching index wins
// Revision : 1.0
// ============================================================================
module mmu_tlb_lookup
    import mmu_pkg::*;
#(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  tlb_entry_t [TLB_ENTRIES-1:0] i_entries,
    input  logic [18:0]                  i_vpn2,
    input  logic [7:0]                   i_asid,
    input  logic                         i_odd,
    output logic                         o_hit,
    output logic [IDX_W-1:0]             o_idx,
    output logic [19:0]                  o_pfn,
    output logic [2:0]                   o_c,
    output logic                         o_d,
    output logic                         o_v
);

    logic [TLB_ENTRIES-1:0] w_match;
    tlb_entry_t             w_sel;

    for (genvar k = 0; k < TLB_ENTRIES; k++) begin : g_match
        assign w_match[k] = (i_entries[k].vpn2 == i_vpn2) &&
                            (i_entries[k].g || (i_entries[k].asid == i_asid));
    end

    // Descending scan so the lowest matching index is the last to assign.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        w_sel = '0;
        for (int k = TLB_ENTRIES - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(k);
                w_sel = i_entries[k];
            end
        end
    end

    assign o_pfn = i_odd ? w_sel.pfn1 : w_sel.pfn0;
    assign o_c   = i_odd ? w_sel.c1   : w_sel.c0;
    assign o_d   = i_odd ? w_sel.d1   : w_sel.d0;
    assign o_v   = i_odd ? w_sel.v1   : w_sel.v0;

endmodule
`default_nettype wire

// File: rtl/mmu_tlb.sv
`default_nettype none
// ============================================================================
// Module   : mmu_tlb
// Brief    : MIPS32 joint-TLB translation unit: I/D ports plus TLBWI/WR/P/R
// Revision : 1.0
// ============================================================================
module mmu_tlb
    import mmu_pkg::*;
#(
    parameter int TLB_ENTRIES = 16
) (
    input  logic     clk,
    input  logic     rst,
    mmu_tlb_if.slave bus
);

    localparam int               IDX_W      = $clog2(TLB_ENTRIES);
    localparam logic [IDX_W-1:0] c_rand_top = IDX_W'(TLB_ENTRIES - 1);

    tlb_entry_t [TLB_ENTRIES-1:0] r_tlb;
    logic [IDX_W-1:0]             r_random;

    logic        r_i_valid, r_i_cached;
    logic [31:0] r_i_paddr;
    logic [2:0]  r_i_exc;
    logic        r_d_valid, r_d_cached;
    logic [31:0] r_d_paddr;
    logic [2:0]  r_d_exc;

    logic             r_tlbp_done, r_tlbp_miss;
    logic [IDX_W-1:0] r_tlbp_index;
    logic             r_tlbr_done;
    logic [31:0]      r_tlbr_hi, r_tlbr_lo0, r_tlbr_lo1;

    logic             w_i_hit, w_i_d, w_i_v;
    logic [IDX_W-1:0] w_i_idx;
    logic [19:0]      w_i_pfn;
    logic [2:0]       w_i_c;
    logic             w_d_hit, w_d_d, w_d_v;
    logic [IDX_W-1:0] w_d_idx;
    logic [19:0]      w_d_pfn;
    logic [2:0]       w_d_c;
    logic             w_p_hit, w_p_d, w_p_v;
    logic [IDX_W-1:0] w_p_idx;
    logic [19:0]      w_p_pfn;
    logic [2:0]       w_p_c;

    mmu_tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES)) u_i_lookup (
        .i_entries (r_tlb),
        .i_vpn2    (bus.i_vaddr[31:13]),
        .i_asid    (bus.cp0_entryhi[7:0]),
        .i_odd     (bus.i_vaddr[12]),
        .o_hit     (w_i_hit),
        .o_idx     (w_i_idx),
        .o_pfn     (w_i_pfn),
        .o_c       (w_i_c),
        .o_d       (w_i_d),
        .o_v       (w_i_v)
    );

    mmu_tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES)) u_d_lookup (
        .i_entries (r_tlb),
        .i_vpn2    (bus.d_vaddr[31:13]),
        .i_asid    (bus.cp0_entryhi[7:0]),
        .i_odd     (bus.d_vaddr[12]),
        .o_hit     (w_d_hit),
        .o_idx     (w_d_idx),
        .o_pfn     (w_d_pfn),
        .o_c       (w_d_c),
        .o_d       (w_d_d),
        .o_v       (w_d_v)
    );

    mmu_tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES)) u_p_lookup (
        .i_entries (r_tlb),
        .i_vpn2    (bus.cp0_entryhi[31:13]),
        .i_asid    (bus.cp0_entryhi[7:0]),
        .i_odd     (1'b0),
        .o_hit     (w_p_hit),
        .o_idx     (w_p_idx),
        .o_pfn     (w_p_pfn),
        .o_c       (w_p_c),
        .o_d       (w_p_d),
        .o_v       (w_p_v)
    );

    logic  w_i_ade, w_d_ade;
    xlat_t w_i_xlat, w_d_xlat;

    assign w_i_ade = |bus.i_vaddr[1:0];
    assign w_d_ade = ((bus.d_width == 2'b10) && bus.d_vaddr[0]) ||
                     ((bus.d_width == 2'b11) && (|bus.d_vaddr[1:0]));

    assign w_i_xlat = xlat_resolve(bus.i_vaddr, w_i_ade, w_i_hit, w_i_pfn, w_i_c,
                                   w_i_d, w_i_v, 1'b0, bus.k0_cached);
    assign w_d_xlat = xlat_resolve(bus.d_vaddr, w_d_ade, w_d_hit, w_d_pfn, w_d_c,
                                   w_d_d, w_d_v, bus.d_we, bus.k0_cached);

    logic             w_wr;
    logic [IDX_W-1:0] w_wr_idx;
    tlb_entry_t       w_new_entry;
    tlb_entry_t       w_rd_entry;

    assign w_wr     = bus.tlbwi || bus.tlbwr;
    assign w_wr_idx = bus.tlbwi ? bus.cp0_index : r_random;

    always_comb begin
        w_new_entry      = '0;
        w_new_entry.vpn2 = bus.cp0_entryhi[31:13];
        w_new_entry.asid = bus.cp0_entryhi[7:0];
        w_new_entry.g    = bus.cp0_entrylo0[LO_G] & bus.cp0_entrylo1[LO_G];
        w_new_entry.pfn0 = bus.cp0_entrylo0[LO_PFN_MSB:LO_PFN_LSB];
        w_new_entry.c0   = bus.cp0_entrylo0[LO_C_MSB:LO_C_LSB];
        w_new_entry.d0   = bus.cp0_entrylo0[LO_D];
        w_new_entry.v0   = bus.cp0_entrylo0[LO_V];
        w_new_entry.pfn1 = bus.cp0_entrylo1[LO_PFN_MSB:LO_PFN_LSB];
        w_new_entry.c1   = bus.cp0_entrylo1[LO_C_MSB:LO_C_LSB];
        w_new_entry.d1   = bus.cp0_entrylo1[LO_D];
        w_new_entry.v1   = bus.cp0_entrylo1[LO_V];
    end

    assign w_rd_entry = r_tlb[bus.cp0_index];

    // Lookups this cycle read the pre-write array; the write lands at the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tlb    <= '0;
            r_random <= c_rand_top;
        end else begin
            if (w_wr) begin
                r_tlb[w_wr_idx] <= w_new_entry;
            end
            r_random <= (r_random == '0) ? c_rand_top : r_random - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_i_valid  <= 1'b0;
            r_i_paddr  <= 32'h1FC0_0000;
            r_i_cached <= 1'b0;
            r_i_exc    <= EXC_NONE;
        end else if (!bus.i_stall) begin
            if (bus.i_req) begin
                r_i_valid  <= 1'b1;
                r_i_paddr  <= w_i_xlat.paddr;
                r_i_cached <= w_i_xlat.cached;
                r_i_exc    <= w_i_xlat.exc;
            end else begin
                r_i_valid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_d_valid  <= 1'b0;
            r_d_paddr  <= '0;
            r_d_cached <= 1'b0;
            r_d_exc    <= EXC_NONE;
        end else if (!bus.d_stall) begin
            if (bus.d_clr) begin
                r_d_valid  <= 1'b0;
                r_d_paddr  <= '0;
                r_d_cached <= 1'b0;
                r_d_exc    <= EXC_NONE;
            end else if (bus.d_req) begin
                r_d_valid  <= 1'b1;
                r_d_paddr  <= w_d_xlat.paddr;
                r_d_cached <= w_d_xlat.cached;
                r_d_exc    <= w_d_xlat.exc;
            end else begin
                r_d_valid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tlbp_done  <= 1'b0;
            r_tlbp_miss  <= 1'b0;
            r_tlbp_index <= '0;
            r_tlbr_done  <= 1'b0;
            r_tlbr_hi    <= '0;
            r_tlbr_lo0   <= '0;
            r_tlbr_lo1   <= '0;
        end else begin
            r_tlbp_done <= bus.tlbp;
            if (bus.tlbp) begin
                r_tlbp_miss  <= !w_p_hit;
                r_tlbp_index <= w_p_hit ? w_p_idx : '0;
            end
            r_tlbr_done <= bus.tlbr;
            if (bus.tlbr) begin
                r_tlbr_hi  <= {w_rd_entry.vpn2, 5'b00000, w_rd_entry.asid};
                r_tlbr_lo0 <= {6'b000000, w_rd_entry.pfn0, w_rd_entry.c0,
                               w_rd_entry.d0, w_rd_entry.v0, w_rd_entry.g};
                r_tlbr_lo1 <= {6'b000000, w_rd_entry.pfn1, w_rd_entry.c1,
                               w_rd_entry.d1, w_rd_entry.v1, w_rd_entry.g};
            end
        end
    end

    assign bus.i_valid       = r_i_valid;
    assign bus.i_paddr       = r_i_paddr;
    assign bus.i_cached      = r_i_cached;
    assign bus.i_exc         = r_i_exc;
    assign bus.d_valid       = r_d_valid;
    assign bus.d_paddr       = r_d_paddr;
    assign bus.d_cached      = r_d_cached;
    assign bus.d_exc         = r_d_exc;
    assign bus.random_o      = r_random;
    assign bus.tlbp_done     = r_tlbp_done;
    assign bus.tlbp_miss     = r_tlbp_miss;
    assign bus.tlbp_index    = r_tlbp_index;
    assign bus.tlbr_done     = r_tlbr_done;
    assign bus.tlbr_entryhi  = r_tlbr_hi;
    assign bus.tlbr_entrylo0 = r_tlbr_lo0;
    assign bus.tlbr_entrylo1 = r_tlbr_lo1;

    // Reserved CP0 bits and lookup fields that no consumer needs.
    logic w_unused_bits;
    assign w_unused_bits = ^{bus.cp0_entryhi[12:8], bus.cp0_entrylo0[31:26],
                             bus.cp0_entrylo1[31:26], w_i_idx, w_d_idx,
                             w_p_pfn, w_p_c, w_p_d, w_p_v};

endmodule
`default_nettype wire

// File: tb/tb_mmu_tlb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmu_tlb
// Brief    : Directed self-checking bench for mmu_tlb
// Revision : 1.0
// ============================================================================
module tb_mmu_tlb;
    import mmu_pkg::*;

    localparam int TLB_ENTRIES = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   m_rand      = TLB_ENTRIES - 1;
    int   wr_idx      = 0;

    mmu_tlb_if #(.TLB_ENTRIES(TLB_ENTRIES)) bus ();

    mmu_tlb #(.TLB_ENTRIES(TLB_ENTRIES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock; track the expected Random register alongside.
    task automatic tick();
        @(posedge clk);
        if (!rst) m_rand = TLB_ENTRIES - 1;
        else      m_rand = (m_rand == 0) ? TLB_ENTRIES - 1 : m_rand - 1;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.i_req = 0; bus.i_stall = 0; bus.i_vaddr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_width = 2'b11; bus.d_clr = 0;
        bus.d_stall = 0; bus.d_vaddr = '0; bus.k0_cached = 0;
        bus.cp0_entryhi = '0; bus.cp0_entrylo0 = '0; bus.cp0_entrylo1 = '0;
        bus.cp0_index = '0;
        bus.tlbwi = 0; bus.tlbwr = 0; bus.tlbp = 0; bus.tlbr = 0;

        rst = 0; tick(); tick();
        check("rst_i_valid", 32'(bus.i_valid), 0);
        check("rst_i_paddr", bus.i_paddr, 32'h1FC0_0000);
        check("rst_d_valid", 32'(bus.d_valid), 0);
        check("rst_d_paddr", bus.d_paddr, 0);
        check("rst_tlbp_done", 32'(bus.tlbp_done), 0);
        check("rst_tlbr_done", 32'(bus.tlbr_done), 0);
        check("rst_random", 32'(bus.random_o), 15);
        rst = 1;
        for (int k = 14; k >= 0; k--) begin
            tick();
            check("random_seq", 32'(bus.random_o), 32'(k));
        end
        tick();
        check("random_wrap", 32'(bus.random_o), 15);

        // Unmapped segments on both ports
        bus.i_req = 1; bus.i_vaddr = 32'hBFC0_0000;
        bus.d_req = 1; bus.d_vaddr = 32'h8000_1000; bus.k0_cached = 1;
        tick();
        check("kseg1_i_valid", 32'(bus.i_valid), 1);
        check("kseg1_i_paddr", bus.i_paddr, 32'h1FC0_0000);
        check("kseg1_i_cached", 32'(bus.i_cached), 0);
        check("kseg1_i_exc", 32'(bus.i_exc), EXC_NONE);
        check("kseg0_d_paddr", bus.d_paddr, 32'h0000_1000);
        check("kseg0_d_cached", 32'(bus.d_cached), 1);
        bus.i_req = 0; bus.d_req = 0;
        tick();
        check("idle_i_valid", 32'(bus.i_valid), 0);
        check("idle_i_paddr_hold", bus.i_paddr, 32'h1FC0_0000);

        // TLBWI entry 3 with a same-cycle lookup of the new page
        bus.cp0_entryhi = 32'h0040_2005; bus.cp0_entrylo0 = 32'h0000_48DA;
        bus.cp0_entrylo1 = 32'h0; bus.cp0_index = 4'd3; bus.tlbwi = 1;
        bus.d_req = 1; bus.d_we = 0; bus.d_width = 2'b11; bus.d_vaddr = 32'h0040_2ABC;
        tick();
        bus.tlbwi = 0;
        check("samecyc_exc", 32'(bus.d_exc), EXC_REFILL);
        check("samecyc_paddr", bus.d_paddr, 0);
        tick();
        check("hit_paddr", bus.d_paddr, 32'h0012_3ABC);
        check("hit_cached", 32'(bus.d_cached), 1);
        check("hit_exc", 32'(bus.d_exc), EXC_NONE);
        bus.d_vaddr = 32'h0040_3000;
        tick();
        check("odd_invalid", 32'(bus.d_exc), EXC_INVALID);
        check("odd_invalid_paddr", bus.d_paddr, 0);
        bus.d_we = 1; bus.d_vaddr = 32'h0040_2000;
        tick();
        check("store_mod", 32'(bus.d_exc), EXC_MOD);
        bus.d_we = 0; bus.d_vaddr = 32'h0040_2ABC; bus.cp0_entryhi = 32'h0040_2006;
        tick();
        check("asid_refill", 32'(bus.d_exc), EXC_REFILL);
        bus.cp0_entryhi = 32'h0040_2005;

        // Alignment errors outrank refill
        bus.d_we = 1; bus.d_width = 2'b11; bus.d_vaddr = 32'h0000_0002;
        tick();
        check("ade_word", 32'(bus.d_exc), EXC_ADE);
        bus.d_width = 2'b10; bus.d_vaddr = 32'h0000_0001;
        tick();
        check("ade_half", 32'(bus.d_exc), EXC_ADE);
        bus.d_width = 2'b00; bus.d_vaddr = 32'h0000_0003;
        tick();
        check("byte_refill", 32'(bus.d_exc), EXC_REFILL);
        bus.d_we = 0; bus.d_width = 2'b11; bus.d_req = 0;
        bus.i_req = 1; bus.i_vaddr = 32'h8000_0002;
        tick();
        check("i_ade", 32'(bus.i_exc), EXC_ADE);
        check("i_ade_paddr", bus.i_paddr, 0);

        // I-side stall holds outputs
        bus.i_vaddr = 32'h8000_0100;
        tick();
        check("pre_stall_paddr", bus.i_paddr, 32'h0000_0100);
        bus.i_stall = 1; bus.i_vaddr = 32'hA000_0200;
        repeat (3) begin
            tick();
            check("stall_paddr", bus.i_paddr, 32'h0000_0100);
            check("stall_valid", 32'(bus.i_valid), 1);
        end
        bus.i_stall = 0;
        tick();
        check("unstall_paddr", bus.i_paddr, 32'h0000_0200);
        check("unstall_cached", 32'(bus.i_cached), 0);
        bus.i_req = 0;

        // d_clr wins over d_req
        bus.d_req = 1; bus.d_vaddr = 32'h8000_0040;
        tick();
        check("pre_clr_paddr", bus.d_paddr, 32'h0000_0040);
        bus.d_clr = 1;
        tick();
        check("clr_valid", 32'(bus.d_valid), 0);
        check("clr_paddr", bus.d_paddr, 0);
        check("clr_cached", 32'(bus.d_cached), 0);
        bus.d_clr = 0; bus.d_req = 0;

        // TLBP hit / miss, TLBR readback
        bus.tlbp = 1; bus.cp0_entryhi = 32'h0040_2005;
        tick();
        check("tlbp_done", 32'(bus.tlbp_done), 1);
        check("tlbp_hit_index", 32'(bus.tlbp_index), 3);
        check("tlbp_hit_miss", 32'(bus.tlbp_miss), 0);
        bus.cp0_entryhi = 32'h0040_2006;
        tick();
        check("tlbp_miss", 32'(bus.tlbp_miss), 1);
        check("tlbp_miss_index", 32'(bus.tlbp_index), 0);
        bus.tlbp = 0; bus.tlbr = 1; bus.cp0_index = 4'd3;
        tick();
        bus.tlbr = 0;
        check("tlbp_pulse", 32'(bus.tlbp_done), 0);
        check("tlbr_done", 32'(bus.tlbr_done), 1);
        check("tlbr_hi", bus.tlbr_entryhi, 32'h0040_2005);
        check("tlbr_lo0", bus.tlbr_entrylo0, 32'h0000_48DA);
        check("tlbr_lo1", bus.tlbr_entrylo1, 32'h0000_0000);

        // TLBWR of a global page at the current Random index
        bus.cp0_entryhi = 32'h1234_6000; bus.cp0_entrylo0 = 32'h02AF_3797;
        bus.cp0_entrylo1 = 32'h0000_0001; bus.tlbwr = 1;
        check("random_at_wr", 32'(bus.random_o), 32'(m_rand));
        wr_idx = m_rand;
        tick();
        bus.tlbwr = 0; bus.tlbr = 1; bus.cp0_index = 4'(wr_idx);
        tick();
        bus.tlbr = 0;
        check("tlbwr_hi", bus.tlbr_entryhi, 32'h1234_6000);
        check("tlbwr_lo0", bus.tlbr_entrylo0, 32'h02AF_3797);
        check("tlbwr_lo1", bus.tlbr_entrylo1, 32'h0000_0001);
        bus.cp0_entryhi = 32'h0000_0006; bus.d_req = 1; bus.d_vaddr = 32'h1234_6010;
        tick();
        check("global_paddr", bus.d_paddr, 32'hABCD_E010);
        check("global_cached", 32'(bus.d_cached), 0);
        check("global_exc", 32'(bus.d_exc), EXC_NONE);
        bus.d_req = 0;

        // Reset mid-operation discards results and clears the array
        bus.i_req = 1; bus.i_vaddr = 32'h8000_0010;
        bus.tlbp = 1; bus.cp0_entryhi = 32'h0040_2005; rst = 0;
        tick();
        check("midrst_i_valid", 32'(bus.i_valid), 0);
        check("midrst_i_paddr", bus.i_paddr, 32'h1FC0_0000);
        check("midrst_tlbp_done", 32'(bus.tlbp_done), 0);
        rst = 1; bus.i_req = 0;
        tick();
        bus.tlbp = 0;
        check("postrst_probe_miss", 32'(bus.tlbp_miss), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
